// File: rtl/sifive_reset_request.sv
// Board reset front end: merges power-on, debounced pushbutton, software and
// PLL-lock-loss sources into a held, lock-qualified areset for the sequencer.
module sifive_reset_request #(
  parameter int unsigned SYNC_STAGES   = 3,
  parameter int unsigned DEBOUNCE_BITS = 8,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned TIMEOUT_BITS  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button_n,
  input  logic       sw_req,
  input  logic       pll_locked,
  input  logic       done,
  output logic       areset,
  output logic       busy,
  output logic [1:0] cause,
  output logic       timeout
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR    = 2'd0;
  localparam logic [1:0] CAUSE_BUTTON = 2'd1;
  localparam logic [1:0] CAUSE_SW     = 2'd2;
  localparam logic [1:0] CAUSE_LOCK   = 2'd3;

  typedef enum logic [1:0] {
    S_ASSERT,
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [TIMEOUT_BITS-1:0] tcnt_q, tcnt_d;
  logic [1:0]              cause_d;
  logic                    timeout_d;
  logic                    areset_d, busy_d;

  logic [SYNC_STAGES-1:0]   button_sync, locked_sync, done_sync;
  logic                     button_s, locked_s, done_s;
  logic                     deb_level, deb_flip, press;
  logic [DEBOUNCE_BITS-1:0] deb_cnt;
  logic                     event_any;
  logic [1:0]               event_cause;

  assign button_s = button_sync[SYNC_STAGES-1];
  assign locked_s = locked_sync[SYNC_STAGES-1];
  assign done_s   = done_sync[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      button_sync <= '1;
      locked_sync <= '0;
      done_sync   <= '0;
    end else begin
      button_sync <= {button_sync[SYNC_STAGES-2:0], button_n};
      locked_sync <= {locked_sync[SYNC_STAGES-2:0], pll_locked};
      done_sync   <= {done_sync[SYNC_STAGES-2:0], done};
    end
  end

  // press fires combinationally on the flip edge so the FSM reacts on that same edge
  assign deb_flip = (button_s != deb_level) && (deb_cnt == '1);
  assign press    = deb_flip && deb_level;

  always_ff @(posedge clock) begin
    if (reset) begin
      deb_level <= 1'b1;
      deb_cnt   <= '0;
    end else if (button_s == deb_level) begin
      deb_cnt   <= '0;
    end else if (deb_flip) begin
      deb_level <= button_s;
      deb_cnt   <= '0;
    end else begin
      deb_cnt   <= deb_cnt + 1'b1;
    end
  end

  always_comb begin
    event_any   = 1'b1;
    event_cause = CAUSE_POR;
    if (!locked_s)   event_cause = CAUSE_LOCK;
    else if (press)  event_cause = CAUSE_BUTTON;
    else if (sw_req) event_cause = CAUSE_SW;
    else             event_any   = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = '0;
    tcnt_d    = '0;
    cause_d   = cause;
    timeout_d = timeout;
    case (state_q)
      S_ASSERT: begin
        if (press || sw_req)       hold_d  = '0;
        else if (hold_q == HOLD_LAST) state_d = S_WAIT_LOCK;
        else                       hold_d  = hold_q + 1'b1;
      end
      S_WAIT_LOCK: begin
        if (press || sw_req) state_d = S_ASSERT;
        else if (locked_s)   state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (event_any) begin
          state_d = S_ASSERT;
          cause_d = event_cause;
        end else if (done_s) begin
          state_d = S_RUN;
        end else if (tcnt_q == '1) begin
          state_d   = S_ASSERT;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (event_any) begin
          state_d = S_ASSERT;
          cause_d = event_cause;
        end
      end
      default: state_d = S_ASSERT;
    endcase
    areset_d = (state_d == S_ASSERT) || (state_d == S_WAIT_LOCK);
    busy_d   = (state_d != S_RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_ASSERT;
      hold_q  <= '0;
      tcnt_q  <= '0;
      areset  <= 1'b1;
      busy    <= 1'b1;
      cause   <= CAUSE_POR;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      tcnt_q  <= tcnt_d;
      areset  <= areset_d;
      busy    <= busy_d;
      cause   <= cause_d;
      timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_sifive_reset_request.sv
// Self-checking bench for sifive_reset_request: directed scenarios plus
// randomized run-time events, timings predicted from the block's rules.
module tb_sifive_reset_request;

  localparam int SYNC = 3;
  localparam int DEB  = 8;
  localparam int HOLD = 16;
  localparam int TOB  = 10;

  logic       clock = 1'b0;
  logic       reset, button_n, sw_req, pll_locked, done;
  logic       areset, busy, timeout;
  logic [1:0] cause;

  int checks = 0;
  int errors = 0;

  sifive_reset_request #(
    .SYNC_STAGES  (SYNC),
    .DEBOUNCE_BITS(DEB),
    .HOLD_CYCLES  (HOLD),
    .TIMEOUT_BITS (TOB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .button_n  (button_n),
    .sw_req    (sw_req),
    .pll_locked(pll_locked),
    .done      (done),
    .areset    (areset),
    .busy      (busy),
    .cause     (cause),
    .timeout   (timeout)
  );

  always #5 clock = ~clock;

  // Reference timing model
  function automatic int exp_press_latency();
    return SYNC + (1 << DEB);
  endfunction
  function automatic int exp_areset_high(input int restart_off);
    return restart_off + HOLD + 1;
  endfunction
  function automatic int exp_sync_react();
    return SYNC + 1;
  endfunction
  function automatic int exp_release_timeout();
    return 1 << TOB;
  endfunction
  function automatic logic [1:0] exp_cause(input bit lock_lost, input bit pressed, input bit sw);
    if (lock_lost) return 2'd3;
    if (pressed)   return 2'd1;
    if (sw)        return 2'd2;
    return 2'd0;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic until_areset(input logic lvl, input int limit, output int n);
    n = 0;
    while (areset !== lvl && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic until_busy(input logic lvl, input int limit, output int n);
    n = 0;
    while (busy !== lvl && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; button_n = 1'b1; sw_req = 1'b0; pll_locked = 1'b1; done = 1'b0;
    step(5);
    reset = 1'b0;
    checks++;
    if ({areset, busy, cause, timeout} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_state: got areset=%b busy=%b cause=%0d timeout=%b expected 1 1 0 0",
               areset, busy, cause, timeout);
    end
    until_areset(1'b0, 100, n);
    checks++;
    if (n !== exp_areset_high(0)) begin
      errors++;
      $display("FAIL por_hold: got %0d cycles expected %0d", n, exp_areset_high(0));
    end
    step(10);
    done = 1'b1;
    until_busy(1'b0, 50, n);
    checks++;
    if (n !== exp_sync_react()) begin
      errors++;
      $display("FAIL por_done_to_run: got %0d expected %0d", n, exp_sync_react());
    end
    checks++;
    if (cause !== exp_cause(0, 0, 0)) begin
      errors++;
      $display("FAIL por_cause: got %0d expected 0", cause);
    end
  endtask

  task automatic test_late_lock();
    int n;
    reset = 1'b1; pll_locked = 1'b0; done = 1'b0;
    step(5);
    reset = 1'b0;
    step(100);
    checks++;
    if (areset !== 1'b1) begin
      errors++;
      $display("FAIL late_lock_wait: got areset=%b expected 1", areset);
    end
    pll_locked = 1'b1;
    until_areset(1'b0, 50, n);
    checks++;
    if (n !== exp_sync_react()) begin
      errors++;
      $display("FAIL late_lock_release: got %0d expected %0d", n, exp_sync_react());
    end
    done = 1'b1;
    until_busy(1'b0, 50, n);
    checks++;
    if (n !== exp_sync_react()) begin
      errors++;
      $display("FAIL late_lock_run: got %0d expected %0d", n, exp_sync_react());
    end
  endtask

  task automatic do_press(input string tag);
    int n;
    button_n = 1'b0;
    until_areset(1'b1, 400, n);
    checks++;
    if (n !== exp_press_latency()) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected %0d", tag, n, exp_press_latency());
    end
    checks++;
    if (cause !== exp_cause(0, 1, 0)) begin
      errors++;
      $display("FAIL %s_cause: got %0d expected 1", tag, cause);
    end
    until_busy(1'b0, 100, n);
    checks++;
    if (n !== exp_areset_high(0) + 1) begin
      errors++;
      $display("FAIL %s_to_run: got %0d expected %0d", tag, n, exp_areset_high(0) + 1);
    end
  endtask

  task automatic test_button();
    int bad;
    int glitch;
    bad = 0;
    for (int g = 0; g < 3; g++) begin
      glitch = (g == 0) ? 10 : int'($urandom_range(1, (1 << DEB) - 20));
      button_n = 1'b0;
      step(glitch);
      button_n = 1'b1;
      for (int i = 0; i < 300; i++) begin
        step();
        if (areset !== 1'b0 || busy !== 1'b0) bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL glitch_ignored: got %0d disturbed cycles expected 0", bad);
    end
    do_press("press");
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (busy !== 1'b0) bad++;
    end
    button_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_and_release_no_event: got %0d busy cycles expected 0", bad);
    end
  endtask

  task automatic test_run_events();
    int n, k, kind;
    bit use_lock, use_sw;
    for (int it = 0; it < 8; it++) begin
      kind     = (it == 0) ? 2 : int'($urandom_range(0, 2));
      use_lock = (kind != 0);
      use_sw   = (kind != 1);
      k        = (it == 1) ? 0 : int'($urandom_range(0, HOLD - 1));
      step($urandom_range(1, 30));
      if (use_lock) begin
        pll_locked = 1'b0;
        step(SYNC);
        checks++;
        if (areset !== 1'b0) begin
          errors++;
          $display("FAIL ev%0d_pre_edge: got areset=%b expected 0", it, areset);
        end
      end
      sw_req = use_sw;
      step();
      sw_req = 1'b0;
      pll_locked = 1'b1;
      checks++;
      if (areset !== 1'b1 || cause !== exp_cause(use_lock, 0, use_sw)) begin
        errors++;
        $display("FAIL ev%0d_event: got areset=%b cause=%0d expected 1 %0d",
                 it, areset, cause, exp_cause(use_lock, 0, use_sw));
      end
      if (k > 0) begin
        step(k - 1);
        sw_req = 1'b1;
        step();
        sw_req = 1'b0;
      end
      until_areset(1'b0, 100, n);
      checks++;
      if (n + k !== exp_areset_high(k)) begin
        errors++;
        $display("FAIL ev%0d_hold: got %0d expected %0d", it, n + k, exp_areset_high(k));
      end
      step();
      checks++;
      if (busy !== 1'b0 || cause !== exp_cause(use_lock, 0, use_sw)) begin
        errors++;
        $display("FAIL ev%0d_run: got busy=%b cause=%0d expected 0 %0d",
                 it, busy, cause, exp_cause(use_lock, 0, use_sw));
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    done = 1'b0;
    step(SYNC + 2);
    sw_req = 1'b1;
    step();
    sw_req = 1'b0;
    for (int r = 0; r < 2; r++) begin
      until_areset(1'b0, 100, n);
      checks++;
      if (n !== exp_areset_high(0) || timeout !== (r != 0)) begin
        errors++;
        $display("FAIL to%0d_hold: got %0d cycles timeout=%b expected %0d %0d",
                 r, n, timeout, exp_areset_high(0), r != 0);
      end
      until_areset(1'b1, 3000, n);
      checks++;
      if (n !== exp_release_timeout() || timeout !== 1'b1 || cause !== 2'd2) begin
        errors++;
        $display("FAIL to%0d_expire: got %0d cycles timeout=%b cause=%0d expected %0d 1 2",
                 r, n, timeout, cause, exp_release_timeout());
      end
    end
    done = 1'b1;
    until_busy(1'b0, 100, n);
    checks++;
    if (n !== exp_areset_high(0) + 1 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_recover: got %0d cycles timeout=%b expected %0d 1",
               n, timeout, exp_areset_high(0) + 1);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    do_press("mid_press");
    button_n = 1'b1;
    step(300);
    checks++;
    if (cause !== 2'd1 || timeout !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_setup: got cause=%0d timeout=%b busy=%b expected 1 1 0", cause, timeout, busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({areset, busy, cause, timeout} !== 5'b11000) begin
      errors++;
      $display("FAIL mid_reset_state: got areset=%b busy=%b cause=%0d timeout=%b expected 1 1 0 0",
               areset, busy, cause, timeout);
    end
    until_areset(1'b0, 100, n);
    checks++;
    if (n !== exp_areset_high(0)) begin
      errors++;
      $display("FAIL mid_reset_hold: got %0d expected %0d", n, exp_areset_high(0));
    end
  endtask

  initial begin
    test_reset();
    test_late_lock();
    test_button();
    test_run_events();
    test_timeout();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sifive_reset_request.md
Name: sifive_reset_request

Overview:
- Front end of the board reset chain: produces the asynchronous `areset` that feeds the reset hold/sync sequencer, and consumes that chain's "last domain out of reset" indication.
- Merges four reset sources: power-on, a glitchy pushbutton, a software request, and PLL lock loss.
- Holds `areset` for a minimum time and waits for PLL lock before releasing. It then waits for the downstream chain to report completion.
- Runs on the free-running board oscillator clock.

Parameters:
- SYNC_STAGES, 3, synchronizer depth for button_n, pll_locked and done (minimum 2).
- DEBOUNCE_BITS, 8, the button must be stable for 2^DEBOUNCE_BITS consecutive cycles before its level is accepted.
- HOLD_CYCLES, 16, exact number of cycles spent in ASSERT (minimum 1).
- TIMEOUT_BITS, 16, the RELEASE state times out after 2^TIMEOUT_BITS cycles without done.

Ports:
- clock, input, 1, free-running oscillator clock.
- reset, input, 1, synchronous, active-high (power-on).
- button_n, input, 1, asynchronous active-low pushbutton, may bounce.
- sw_req, input, 1, synchronous to clock; a one-cycle pulse requests a reset.
- pll_locked, input, 1, asynchronous PLL lock status.
- done, input, 1, asynchronous; high when the last downstream domain is out of reset.
- areset, output, 1, reset request to the sequencer; registered and glitch-free.
- busy, output, 1, high whenever state != RUN.
- cause, output, 2, last reset cause: 0 = power-on, 1 = button, 2 = software, 3 = lock loss.
- timeout, output, 1, sticky; set when RELEASE times out.

Behaviour:
- Reset is one clock, synchronous and active-high. Reset has priority over everything and takes effect at the next clock edge. It forces:
  - state = ASSERT, hold counter = 0, areset = 1, busy = 1, cause = 0, timeout = 0;
  - button synchronizer and debounced level = 1 (released), debounce counter = 0;
  - pll_locked and done synchronizers = 0.
- Synchronizers: plain SYNC_STAGES-flop chains. Their outputs are button_s, locked_s and done_s, each SYNC_STAGES cycles behind the pin.
- Debounce:
  - The counter clears whenever button_s equals the debounced level. Otherwise it increments.
  - When it reaches 2^DEBOUNCE_BITS-1 while still differing, the debounced level flips and the counter clears.
  - press = one-cycle pulse on a debounced 1 -> 0 transition. Release generates nothing.
- The areset flop is updated together with the state register: 1 in ASSERT and WAIT_LOCK, 0 in RELEASE and RUN. There is no extra latency versus state.
- ASSERT:
  - The counter increments each cycle. After the cycle with counter == HOLD_CYCLES-1, go to WAIT_LOCK. ASSERT therefore lasts exactly HOLD_CYCLES cycles.
  - press or sw_req during ASSERT clears the counter, restarting the hold. cause is not updated.
- WAIT_LOCK:
  - Stay while locked_s = 0, with no limit.
  - When locked_s = 1, go to RELEASE. The minimum dwell is 1 cycle.
  - press or sw_req returns to ASSERT with the counter cleared. cause is not updated.
- RELEASE:
  - A timeout counter runs, cleared on entry.
  - When done_s = 1, go to RUN.
  - A lock-loss, press or sw_req event goes to ASSERT and updates cause.
  - If the counter reaches 2^TIMEOUT_BITS-1 without done_s, set timeout = 1 and go to ASSERT; cause is unchanged.
- RUN:
  - locked_s = 0 sets cause = 3, press sets cause = 1, sw_req sets cause = 2. Any of these goes to ASSERT.
  - If several happen in the same cycle, priority is lock loss > button > software.
- cause updates on the same edge as the transition into ASSERT. timeout clears only on reset.
- Width rules: the hold counter is clog2(HOLD_CYCLES) bits wide, minimum 1. The timeout counter is TIMEOUT_BITS wide. Neither counter may wrap; both are compared at terminal count.

Test Plan:
1. Power-on: reset = 1 for 5 cycles, pll_locked = 1, button_n = 1; done rises 10 cycles after areset falls.
   -> areset is high for exactly 17 cycles after reset falls (16 ASSERT + 1 WAIT_LOCK); busy falls 4 cycles after the done edge; cause = 0.
2. Late lock: pll_locked rises 100 cycles after reset falls.
   -> areset falls exactly 4 cycles after the pll_locked edge (3 synchronizer + 1).
3. Button, DEBOUNCE_BITS = 8, in RUN:
   - 10-cycle low glitch -> no change.
   - Low held for 300 cycles -> areset rises 3 + 256 cycles after the falling edge; cause = 1; holding the button afterwards causes no second event.
4. Simultaneous events in RUN: sw_req pulses in the same cycle that locked_s falls.
   -> cause = 3; areset rises the next cycle.
   A lone sw_req in RUN -> cause = 2; ASSERT lasts 16 cycles.
5. Timeout, TIMEOUT_BITS = 10, done held at 0.
   -> After 1024 cycles in RELEASE: timeout = 1, areset returns to 1, cause is unchanged. The sequence then repeats with timeout still 1.
6. Reset mid-operation: assert reset for 1 cycle while in RUN with cause = 1 and timeout = 1.
   -> Next cycle: areset = 1, busy = 1, cause = 0, timeout = 0, full 16-cycle hold.
